// File: rtl/action_irq_pkg.sv
// Shared types and helpers for the action interrupt bridge and its arbiter.
package action_irq_pkg;

  // Request handshake states: waiting for work, request outstanding, forced low cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Widest request vector the round-robin helper can scan.
  localparam int MAX_SRC = 32;

  // Width of the SNAP source index field (SRC_W) for a given interrupt width.
  function automatic int src_width(input int int_bits);
    return int_bits - 1;
  endfunction

  // Width of the ack timeout counter (TO_W): ceil(log2(t+1)), at least one bit.
  function automatic int to_width(input int ack_timeout);
    int w;
    w = $clog2(ack_timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Round-robin pick: first set bit of eligible at or after ptr, wrapping at n.
  // Returns ptr when nothing is eligible; callers qualify with their own any flag.
  function automatic int next_rr(input int ptr, input logic [MAX_SRC-1:0] eligible,
                                 input int n);
    int idx;
    next_rr = ptr;
    // Scan from the farthest offset down so the nearest eligible index is written last.
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (eligible[idx[4:0]]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/action_irq_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module action_irq_rr_arb
  import action_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [MAX_SRC-1:0] req_ext;

  // Widen the request vector to the helper's scan width and pick the winner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = req;
    any                    = |req;
    gnt_idx                = IDX_W'(next_rr(int'(ptr), req_ext, NUM_SRC));
  end

endmodule

// File: rtl/action_irq_bridge.sv
// Bridges NUM_SRC accelerator interrupt lines onto the single SNAP action
// interrupt: per-source pending latches, round-robin grant, ack handshake and
// an optional ack timeout that flags a sticky error and retries the source.
module action_irq_bridge
  import action_irq_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int INT_BITS     = 3,
  parameter int CONTEXT_BITS = 8,
  parameter int EDGE_MODE    = 1,
  parameter int ACK_TIMEOUT  = 0
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_SRC-1:0]      src_irq_i,
  input  logic [NUM_SRC-1:0]      src_mask_i,
  input  logic [CONTEXT_BITS-1:0] ctx_i,
  input  logic                    ctx_valid_i,
  output logic                    interrupt,
  output logic [INT_BITS-2:0]     interrupt_src,
  output logic [CONTEXT_BITS-1:0] interrupt_ctx,
  input  logic                    interrupt_ack,
  output logic [NUM_SRC-1:0]      pending_o,
  output logic                    timeout_err_o,
  input  logic                    clr_err_i
);

  localparam int SRC_W = src_width(INT_BITS);
  localparam int TO_W  = to_width(ACK_TIMEOUT);
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t                  state_q, state_d;
  logic [NUM_SRC-1:0]      pend_q, pend_d, prev_q;
  logic [NUM_SRC-1:0]      set_vec, clr_vec, eligible;
  logic [SRC_W-1:0]        ptr_q, ptr_d, src_q, src_d, gnt_idx;
  logic [CONTEXT_BITS-1:0] ctx_q, ctx_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic                    irq_q, irq_d, err_q, err_d, to_fire, any;

  // Only unmasked pending sources compete; masked ones keep their latch.
  assign eligible = pend_q & ~src_mask_i;

  action_irq_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (SRC_W)
  ) u_arb (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Next-state, capture and handshake decisions.
  always_comb begin
    set_vec = (EDGE_MODE != 0) ? (src_irq_i & ~prev_q & ~src_mask_i)
                               : (src_irq_i & ~src_mask_i);
    state_d = state_q;
    irq_d   = irq_q;
    src_d   = src_q;
    ctx_d   = ctx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    clr_vec = '0;
    to_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && ctx_valid_i) begin
          state_d = REQ;
          irq_d   = 1'b1;
          src_d   = gnt_idx;
          ctx_d   = ctx_i;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // Ack is checked first so it beats a timeout landing in the same cycle.
        if (interrupt_ack) begin
          clr_vec[src_q] = 1'b1;
          ptr_d   = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + 1'b1;
          irq_d   = 1'b0;
          state_d = GAP;
        end else if (TIMEOUT_EN && (cnt_q == TO_LAST)) begin
          to_fire = 1'b1;
          irq_d   = 1'b0;
          state_d = GAP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new set on the acked source wins over its clear.
    pend_d = (pend_q & ~clr_vec) | set_vec;
    // A timeout in the same cycle as a clear keeps the flag raised.
    err_d  = (err_q & ~clr_err_i) | to_fire;
  end

  // State, latches and registered SNAP outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      prev_q  <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      ctx_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= src_irq_i;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign interrupt     = irq_q;
  assign interrupt_src = src_q;
  assign interrupt_ctx = ctx_q;
  assign pending_o     = pend_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_action_irq_bridge.sv
// Bench for action_irq_bridge: an edge-mode instance with a 16-cycle ack
// timeout and a level-mode instance without timeout share one stimulus; a
// rule-level model tracks both and is compared every cycle, alongside
// directed literal expectations.
module tb_action_irq_bridge;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src_irq = '0, mask = '0;
  logic [7:0] ctx = '0;
  logic       ctxv = 1'b0, ack = 1'b0, clr_err = 1'b0;

  logic       e_int, l_int, e_err, l_err;
  logic [1:0] e_src, l_src;
  logic [7:0] e_ctx, l_ctx;
  logic [3:0] e_pend, l_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  action_irq_bridge #(.NUM_SRC(4), .INT_BITS(3), .CONTEXT_BITS(8),
                      .EDGE_MODE(1), .ACK_TIMEOUT(TO)) u_edge (
    .ap_clk(clk), .ap_rst_n(rst_n), .src_irq_i(src_irq), .src_mask_i(mask),
    .ctx_i(ctx), .ctx_valid_i(ctxv), .interrupt(e_int), .interrupt_src(e_src),
    .interrupt_ctx(e_ctx), .interrupt_ack(ack), .pending_o(e_pend),
    .timeout_err_o(e_err), .clr_err_i(clr_err));

  action_irq_bridge #(.NUM_SRC(4), .INT_BITS(3), .CONTEXT_BITS(8),
                      .EDGE_MODE(0), .ACK_TIMEOUT(0)) u_level (
    .ap_clk(clk), .ap_rst_n(rst_n), .src_irq_i(src_irq), .src_mask_i(mask),
    .ctx_i(ctx), .ctx_valid_i(ctxv), .interrupt(l_int), .interrupt_src(l_src),
    .interrupt_ctx(l_ctx), .interrupt_ack(ack), .pending_o(l_pend),
    .timeout_err_o(l_err), .clr_err_i(clr_err));

  // Model view: a request is either outstanding (irq), in its mandatory low
  // cycle (cooling), or neither; age counts cycles the request has been up.
  typedef struct packed {
    logic [3:0]  pend;
    logic [3:0]  prev;
    logic [1:0]  ptr;
    logic        irq;
    logic        cooling;
    logic [31:0] age;
    logic [1:0]  src;
    logic [7:0]  ctx;
    logic        err;
  } mdl_t;

  mdl_t me, ml;

  function automatic mdl_t mdl_next(input mdl_t m, input bit edge_mode, input int tmo);
    mdl_t n;
    logic [3:0] fresh, elig;
    bit fired;
    int w, idx;
    n = m;
    fired = 1'b0;
    fresh = edge_mode ? (src_irq & ~m.prev & ~mask) : (src_irq & ~mask);
    n.prev = src_irq;
    if (m.cooling) begin
      n.cooling = 1'b0;
    end else if (!m.irq) begin
      elig = m.pend & ~mask;
      if (elig != 4'd0 && ctxv) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (int'(m.ptr) + k) % 4;
          if (w < 0 && elig[idx[1:0]]) w = idx;
        end
        n.irq = 1'b1;
        n.src = 2'(w);
        n.ctx = ctx;
        n.age = 32'd1;
      end
    end else begin
      if (ack) begin
        n.pend[m.src] = 1'b0;
        n.ptr = m.src + 2'd1;
        n.irq = 1'b0;
        n.cooling = 1'b1;
      end else if (tmo > 0 && m.age >= 32'(tmo)) begin
        fired = 1'b1;
        n.irq = 1'b0;
        n.cooling = 1'b1;
      end else begin
        n.age = m.age + 32'd1;
      end
    end
    n.pend = n.pend | fresh;
    n.err = fired ? 1'b1 : (clr_err ? 1'b0 : m.err);
    return n;
  endfunction

  // Advance both models on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me <= '0;
      ml <= '0;
    end else begin
      me <= mdl_next(me, 1'b1, TO);
      ml <= mdl_next(ml, 1'b0, 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the models, away from the active edge.
  always @(negedge clk) begin
    chk("edge_model",  32'({e_int, e_src, e_ctx, e_pend, e_err}),
                       32'({me.irq, me.src, me.ctx, me.pend, me.err}));
    chk("level_model", 32'({l_int, l_src, l_ctx, l_pend, l_err}),
                       32'({ml.irq, ml.src, ml.ctx, ml.pend, ml.err}));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input int bound);
    int i = 0;
    while (!e_int && i < bound) begin
      step();
      i++;
    end
    chk("irq_seen", 32'(e_int), 32'd1);
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    while (e_int && hi < 40) begin
      hi++;
      step();
    end
  endtask

  task automatic do_reset();
    src_irq = '0; mask = '0; ctx = '0; ctxv = 1'b1; ack = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt, hi, i;
    logic [1:0] exp_src [3];
    logic [3:0] exp_pend[3];
    exp_src  = '{2'd0, 2'd1, 2'd3};
    exp_pend = '{4'b1011, 4'b1010, 4'b1000};

    // Reset state
    ctxv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_int", 32'(e_int), 32'd0);
    chk("rst_src", 32'(e_src), 32'd0);
    chk("rst_ctx", 32'(e_ctx), 32'd0);
    chk("rst_pend", 32'(e_pend), 32'd0);
    chk("rst_err", 32'(e_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single edge on source 2
    ctx = 8'h5A; src_irq = 4'b0100;
    step();
    src_irq = '0;
    chk("t1_pend", 32'(e_pend), 32'h4);
    chk("t1_int_early", 32'(e_int), 32'd0);
    step();
    chk("t1_int", 32'(e_int), 32'd1);
    chk("t1_src", 32'(e_src), 32'd2);
    chk("t1_ctx", 32'(e_ctx), 32'h5A);
    ctx = 8'h33;
    step(); step();
    chk("t1_ctx_hold", 32'(e_ctx), 32'h5A);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_int_drop", 32'(e_int), 32'd0);
    chk("t1_pend_clr", 32'(e_pend), 32'd0);
    repeat (3) step();
    ack = 1'b1; step(); ack = 1'b0;   // stray ack while idle
    step();
    chk("t1_idle_ack", 32'(e_int), 32'd0);

    // Round robin across sources 0, 1, 3
    do_reset();
    src_irq = 4'b1011;
    step();
    src_irq = '0;
    chk("rr_pend0", 32'(e_pend), 32'hB);
    for (int g = 0; g < 3; g++) begin
      wait_int(10);
      chk("rr_src", 32'(e_src), 32'(exp_src[g]));
      chk("rr_pend", 32'(e_pend), 32'(exp_pend[g]));
      step(); step();
      ack = 1'b1; step(); ack = 1'b0;
      chk("rr_drop", 32'(e_int), 32'd0);
      if (g < 2) begin
        lowcnt = 1;
        while (!e_int && lowcnt < 10) begin
          step();
          if (!e_int) lowcnt++;
        end
        chk("rr_gap_ok", 32'(lowcnt >= 1), 32'd1);
      end
    end
    chk("rr_pend_end", 32'(e_pend), 32'd0);

    // Masking
    do_reset();
    mask = 4'b0010; src_irq = 4'b0010;
    step();
    src_irq = '0;
    step(); step();
    chk("mk_no_pend", 32'(e_pend), 32'd0);
    chk("mk_no_int", 32'(e_int), 32'd0);
    ctxv = 1'b0; mask = '0; src_irq = 4'b0010;
    step();
    src_irq = '0; mask = 4'b0010; ctxv = 1'b1;
    chk("mk_pend_set", 32'(e_pend), 32'h2);
    ack = 1'b1; step(); ack = 1'b0;
    step(); step();
    chk("mk_pend_keep", 32'(e_pend), 32'h2);
    chk("mk_held", 32'(e_int), 32'd0);
    mask = '0;
    step();
    chk("mk_unmask_int", 32'(e_int), 32'd1);
    chk("mk_unmask_src", 32'(e_src), 32'd1);
    step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("mk_pend_end", 32'(e_pend), 32'd0);

    // Ack timeout and retry
    do_reset();
    src_irq = 4'b1000;
    step();
    src_irq = '0;
    wait_int(5);
    count_high(hi);
    chk("to_len", 32'(hi), 32'd16);
    chk("to_err", 32'(e_err), 32'd1);
    chk("to_pend", 32'(e_pend), 32'h8);
    wait_int(5);
    chk("to_retry_src", 32'(e_src), 32'd3);
    clr_err = 1'b1;
    count_high(hi);
    clr_err = 1'b0;
    chk("to_len2", 32'(hi), 32'd16);
    chk("to_err_wins", 32'(e_err), 32'd1);
    wait_int(5);
    ack = 1'b1; step(); ack = 1'b0;
    chk("to_pend_clr", 32'(e_pend), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("to_err_clr", 32'(e_err), 32'd0);

    // Level capture: source held high through its ack
    do_reset();
    src_irq = 4'b0001;
    wait_int(5);
    chk("lv_int", 32'(l_int), 32'd1);
    chk("lv_src", 32'(l_src), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lv_drop", 32'(l_int), 32'd0);
    chk("lv_repend", 32'(l_pend), 32'h1);
    chk("lv_edge_pend", 32'(e_pend), 32'd0);
    i = 0;
    while (!l_int && i < 5) begin step(); i++; end
    chk("lv_second", 32'(l_int), 32'd1);
    chk("lv_second_src", 32'(l_src), 32'd0);
    src_irq = '0;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("lv_pend_end", 32'(l_pend), 32'd0);
    chk("lv_edge_quiet", 32'(e_int), 32'd0);

    // Reset in the middle of a request
    do_reset();
    src_irq = 4'b0100;
    wait_int(5);
    count_high(hi);
    chk("mr_err_pre", 32'(e_err), 32'd1);
    wait_int(5);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_int", 32'(e_int), 32'd0);
    chk("mr_pend", 32'(e_pend), 32'd0);
    chk("mr_err", 32'(e_err), 32'd0);
    chk("mr_lint", 32'(l_int), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_int(5);
    chk("mr_new_src", 32'(e_src), 32'd2);
    ack = 1'b1; step(); ack = 1'b0;
    repeat (6) step();
    chk("mr_once_int", 32'(e_int), 32'd0);
    chk("mr_once_pend", 32'(e_pend), 32'd0);
    src_irq = '0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
